// File: rtl/motctl_sequencer.sv
// motctl_sequencer: queued {MotCtl, duration} scheduler on the PicoBlaze bus; MOTSEQ_LOOP_EN adds loop re-push
module motctl_sequencer #(
    parameter int         DEPTH       = 8,
    parameter int         TICK_DIV    = 100000,
    parameter logic [7:0] IDLE_MOTCTL = 8'h00,
    parameter logic [7:0] PA_SEQ_DUR  = 8'h19,
    parameter logic [7:0] PA_SEQ_MOT  = 8'h1A,
    parameter logic [7:0] PA_SEQ_CTL  = 8'h1B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] PortID,
    input  logic [7:0] DataIn,
    input  logic       WriteStrobe,
    output logic [7:0] MotCtl,
    output logic [7:0] SeqStatus,
    output logic       SeqIntr,
    input  logic       SeqIntrAck
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
    state_t          r_state, w_next;
    logic [15:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_rd, r_wr;
    logic [3:0]      r_count;
    logic [7:0]      r_dur, r_mot, r_ticks;
    logic [PW-1:0]   r_presc;
    logic            r_pause, r_ovf, r_intr;
    logic [15:0]     w_head;
    logic            w_wr_dur, w_wr_mot, w_wr_ctl, w_flush, w_empty, w_full, w_tick, w_end;
    logic            w_pop, w_drain, w_rep, w_room, w_push, w_ovf;
    assign w_wr_dur = WriteStrobe && PortID == PA_SEQ_DUR;
    assign w_wr_mot = WriteStrobe && PortID == PA_SEQ_MOT;
    assign w_wr_ctl = WriteStrobe && PortID == PA_SEQ_CTL;
    assign w_flush  = w_wr_ctl && DataIn[0];
    assign w_empty  = r_count == 4'd0;
    assign w_full   = r_count == 4'(DEPTH);
    assign w_head   = r_mem[r_rd];
    assign w_tick   = r_presc == PW'(TICK_DIV - 1);
    // a zero duration holds the entry until another one is queued
    assign w_end    = r_ticks == 8'd0 ? !w_empty : w_tick && r_ticks == 8'd1;
    assign w_room   = r_count < 4'(DEPTH) || (w_pop && !w_rep);
    assign w_push   = w_wr_mot && w_room;
    assign w_ovf    = w_wr_mot && !w_room;
`ifdef MOTSEQ_LOOP_EN
    logic r_loop;
    always_ff @(posedge clk) begin
        if (rst) r_loop <= 1'b0;
        else if (w_wr_ctl) r_loop <= DataIn[2];
    end
    assign w_rep = w_pop && r_loop;
`else
    assign w_rep = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_pop   = !w_flush && !w_empty && (r_state == S_IDLE ? !r_pause : r_state == S_RUN && w_end);
        w_drain = !w_flush && r_state == S_RUN && w_end && w_empty;
        w_next  = (w_flush || w_drain) ? S_IDLE :
                  w_pop ? S_RUN :
                  (r_state == S_RUN && r_pause) ? S_PAUSE :
                  (r_state == S_PAUSE && !r_pause) ? S_RUN : r_state;
    end
    always_comb begin
        MotCtl = r_state == S_RUN ? r_mot : IDLE_MOTCTL;
    end
    assign SeqStatus = {r_ovf, r_state != S_IDLE, w_empty, w_full, r_count};
    assign SeqIntr   = r_intr;
    always_ff @(posedge clk) begin
        if (w_rep) r_mem[r_wr] <= w_head;
        if (w_push) r_mem[r_wr + AW'(w_rep)] <= {DataIn, r_dur};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_dur   <= '0;
            r_mot   <= IDLE_MOTCTL;
            r_ticks <= '0;
            r_presc <= '0;
            r_pause <= 1'b0;
            r_ovf   <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            if (w_wr_dur) r_dur <= DataIn;
            if (w_wr_ctl) r_pause <= DataIn[1];
            r_intr <= w_drain || (r_intr && !SeqIntrAck);
            if (w_flush) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_rd    <= r_rd + AW'(w_pop);
                r_wr    <= r_wr + AW'(w_rep) + AW'(w_push);
                r_count <= r_count + 4'(w_rep) + 4'(w_push) - 4'(w_pop);
                r_ovf   <= r_ovf || w_ovf;
            end
            if (w_pop) begin
                r_mot   <= w_head[15:8];
                r_ticks <= w_head[7:0];
                r_presc <= '0;
            end else if (r_state == S_RUN) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick && r_ticks != 8'd0) r_ticks <= r_ticks - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_motctl_sequencer.sv
// tb_motctl_sequencer: directed and random stimulus against a queue/remaining-cycles reference model
module tb_motctl_sequencer;
    localparam int DEPTH = 8;
    localparam int TD    = 4;
    localparam logic [7:0] P_DUR = 8'h19, P_MOT = 8'h1A, P_CTL = 8'h1B;
`ifdef MOTSEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst, WriteStrobe, SeqIntr, SeqIntrAck;
    logic [7:0] PortID, DataIn, MotCtl, SeqStatus;
    int total = 0, bad = 0;
    logic [15:0] mq[$];
    bit         m_act, m_paused, m_inf, m_pause, m_loop, m_ovf, m_intr;
    logic [7:0] m_mot, m_dur;
    int         m_rem;
    int         hist[256];
    int         drops, rises;
    logic [7:0] prev_mot;
    logic       prev_intr;

    always #5 clk = ~clk;

    motctl_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .PortID(PortID), .DataIn(DataIn), .WriteStrobe(WriteStrobe),
        .MotCtl(MotCtl), .SeqStatus(SeqStatus), .SeqIntr(SeqIntr), .SeqIntrAck(SeqIntrAck)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic ws, input logic [7:0] pid, input logic [7:0] din, input logic ack, input logic rs);
        bit flush, pop, drain, done;
        logic [15:0] e;
        if (rs) begin
            mq.delete();
            {m_act, m_paused, m_inf, m_pause, m_loop, m_ovf, m_intr} = '0;
            m_mot = 8'h00;
            m_dur = 8'h00;
            m_rem = 0;
            return;
        end
        flush = ws && pid == P_CTL && din[0];
        pop = 0;
        drain = 0;
        if (!m_act) pop = !m_pause && mq.size() > 0;
        else if (m_paused) m_paused = m_pause;
        else begin
            if (m_inf) done = mq.size() > 0;
            else begin
                m_rem--;
                done = m_rem == 0;
            end
            if (done) begin
                pop = mq.size() > 0;
                drain = mq.size() == 0;
            end else m_paused = m_pause;
        end
        if (flush) begin
            pop = 0;
            drain = 0;
        end
        if (pop) begin
            e = mq.pop_front();
            if (m_loop) mq.push_back(e);
            m_act = 1;
            m_paused = 0;
            m_mot = e[15:8];
            m_inf = e[7:0] == 8'h00;
            m_rem = int'(e[7:0]) * TD;
        end
        if (drain) begin
            m_act = 0;
            m_intr = 1;
        end else if (ack) m_intr = 0;
        if (ws && pid == P_MOT) begin
            if (mq.size() < DEPTH) mq.push_back({din, m_dur});
            else m_ovf = 1;
        end
        if (ws && pid == P_DUR) m_dur = din;
        if (ws && pid == P_CTL) begin
            m_pause = din[1];
            m_loop = LOOP_EN && din[2];
        end
        if (flush) begin
            mq.delete();
            m_ovf = 0;
            m_act = 0;
            m_paused = 0;
        end
    endtask

    task automatic step(input logic ws, input logic [7:0] pid, input logic [7:0] din, input logic ack, input logic rs);
        WriteStrobe = ws;
        PortID = pid;
        DataIn = din;
        SeqIntrAck = ack;
        rst = rs;
        @(posedge clk);
        model(ws, pid, din, ack, rs);
        #1;
        chk("mot", MotCtl, (m_act && !m_paused) ? m_mot : 8'h00);
        chk("status", SeqStatus, {m_ovf, m_act, mq.size() == 0, mq.size() == DEPTH, 4'(mq.size())});
        chk("intr", {7'b0, SeqIntr}, {7'b0, m_intr});
        hist[int'(MotCtl)]++;
        if (prev_mot != 8'h00 && MotCtl == 8'h00) drops++;
        if (SeqIntr && !prev_intr) rises++;
        prev_mot = MotCtl;
        prev_intr = SeqIntr;
        WriteStrobe = 1'b0;
        SeqIntrAck = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] pid, input logic [7:0] din);
        step(1'b1, pid, din, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 256; i++) hist[i] = 0;
        drops = 0;
        rises = 0;
    endtask

    initial begin
        prev_mot = 8'h00;
        prev_intr = 1'b0;
        clear_hist();
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("rst_mot", MotCtl, 8'h00);
        chk("rst_status", SeqStatus, 8'h20);
        chk("rst_intr", {7'b0, SeqIntr}, 8'h00);

        clear_hist();
        wr(P_DUR, 8'd3);
        wr(P_MOT, 8'h33);
        idle(30);
        chk("hold_33", 8'(hist[8'h33]), 8'd12);
        chk("drain_intr", {7'b0, SeqIntr}, 8'h01);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("ack_intr", {7'b0, SeqIntr}, 8'h00);

        clear_hist();
        wr(P_DUR, 8'd2);
        wr(P_MOT, 8'h11);
        wr(P_DUR, 8'd1);
        wr(P_MOT, 8'h22);
        idle(20);
        chk("hold_11", 8'(hist[8'h11]), 8'd8);
        chk("hold_22", 8'(hist[8'h22]), 8'd4);
        chk("no_gap", 8'(drops), 8'd1);
        chk("one_intr", 8'(rises), 8'd1);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        wr(P_CTL, 8'h02);
        wr(P_DUR, 8'd1);
        for (int i = 0; i < 9; i++) wr(P_MOT, 8'(8'h60 + i));
        chk("ovf_status", SeqStatus, 8'h98);
        chk("ovf_paused_mot", MotCtl, 8'h00);
        wr(P_CTL, 8'h00);
        wr(P_MOT, 8'h70);
        chk("full_pushpop", SeqStatus, 8'hD8);
        wr(P_CTL, 8'h01);
        chk("flush_status", SeqStatus, 8'h20);
        chk("flush_mot", MotCtl, 8'h00);

        clear_hist();
        wr(P_DUR, 8'd3);
        wr(P_MOT, 8'h44);
        idle(4);
        wr(P_CTL, 8'h02);
        chk("pre_pause", 8'(hist[8'h44]), 8'd5);
        idle(4);
        chk("paused_mot", MotCtl, 8'h00);
        chk("paused_status", SeqStatus, 8'h60);
        wr(P_CTL, 8'h00);
        idle(12);
        chk("post_pause", 8'(hist[8'h44] - 5), 8'd7);
        chk("pause_intr", {7'b0, SeqIntr}, 8'h01);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        wr(P_DUR, 8'd3);
        wr(P_MOT, 8'h55);
        wr(P_MOT, 8'h56);
        idle(3);
        wr(P_CTL, 8'h01);
        chk("fl_mot", MotCtl, 8'h00);
        chk("fl_status", SeqStatus, 8'h20);
        idle(20);
        chk("fl_intr", {7'b0, SeqIntr}, 8'h00);

        wr(P_DUR, 8'd2);
        wr(P_MOT, 8'h57);
        wr(P_MOT, 8'h58);
        idle(3);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("rr_mot", MotCtl, 8'h00);
        chk("rr_status", SeqStatus, 8'h20);
        chk("rr_intr", {7'b0, SeqIntr}, 8'h00);
        wr(P_MOT, 8'h77);
        idle(20);
        chk("inf_hold", MotCtl, 8'h77);
        chk("inf_status", SeqStatus, 8'h60);
        chk("inf_intr", {7'b0, SeqIntr}, 8'h00);
        wr(P_DUR, 8'd1);
        wr(P_MOT, 8'h78);
        idle(1);
        chk("inf_next", MotCtl, 8'h78);
        idle(6);
        chk("inf_drain", {7'b0, SeqIntr}, 8'h01);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

`ifdef MOTSEQ_LOOP_EN
        clear_hist();
        wr(P_CTL, 8'h04);
        wr(P_DUR, 8'd1);
        wr(P_MOT, 8'hA1);
        wr(P_MOT, 8'hA2);
        idle(31);
        chk("loop_a1", 8'(hist[8'hA1]), 8'd16);
        chk("loop_a2", 8'(hist[8'hA2]), 8'd16);
        chk("loop_nodrop", 8'(drops), 8'd0);
        chk("loop_nointr", 8'(rises), 8'd0);
        wr(P_CTL, 8'h01);
`endif

        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            else if (r < 24) wr(P_MOT, 8'($urandom));
            else if (r < 34) wr(P_DUR, 8'($urandom_range(0, 3)));
            else if (r < 39) wr(P_CTL, {5'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0});
            else if (r < 45) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            else idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
